// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - N-channel pushbutton debouncer with press/release/hold pulses
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses after hold fires.
module multi_debounce #(
  parameter int N_CH         = 5,
  parameter int TICK_DIV     = 100_000,
  parameter int STABLE_TICKS = 20,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic            clk100M,
  input  logic            reset,
  input  logic [N_CH-1:0] buttons,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] hold
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic [N_CH-1:0] sync_a;
  logic [N_CH-1:0] sync_b;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [SW-1:0]   stable   [N_CH];
  logic [HW-1:0]   hold_cnt [N_CH];
  logic [N_CH-1:0] accept;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0]   rep_cnt  [N_CH];
`endif

  always_ff @(posedge clk100M) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= buttons;
      sync_b <= sync_a;
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk100M) begin
    if (reset || tick) presc <= '0;
    else               presc <= presc + PW'(1);
  end

  // A channel flips on the tick that completes STABLE_TICKS disagreeing samples.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_CH; i++)
      accept[i] = tick && (sync_b[i] != level[i]) && (stable[i] == SW'(STABLE_TICKS - 1));
  end

  always_ff @(posedge clk100M) begin
    if (reset) begin
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      hold          <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stable[i]   <= '0;
        hold_cnt[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
        rep_cnt[i]  <= '0;
`endif
      end
    end else begin
      press         <= '0;
      release_pulse <= '0;
      hold          <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (accept[i]) begin
          stable[i]        <= '0;
          level[i]         <= ~level[i];
          press[i]         <= ~level[i];
          release_pulse[i] <= level[i];
        end else if (tick) begin
          if (sync_b[i] != level[i]) stable[i] <= stable[i] + SW'(1);
          else                       stable[i] <= '0;
        end

        // A falling acceptance wins over a hold threshold reached on the same tick.
        if (accept[i] && level[i]) begin
          hold_cnt[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
          rep_cnt[i]  <= '0;
`endif
        end else if (tick && level[i]) begin
          if (hold_cnt[i] != HW'(HOLD_TICKS)) begin
            hold_cnt[i] <= hold_cnt[i] + HW'(1);
            hold[i]     <= (hold_cnt[i] == HW'(HOLD_TICKS - 1));
          end
`ifdef DEBOUNCE_REPEAT_EN
          else if (rep_cnt[i] == RW'(REPEAT_TICKS - 1)) begin
            rep_cnt[i] <= '0;
            press[i]   <= 1'b1;
          end else begin
            rep_cnt[i] <= rep_cnt[i] + RW'(1);
          end
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_debounce.sv
// tb/tb_multi_debounce.sv - self-checking bench for multi_debounce with a tick-level reference model
// Honours DEBOUNCE_REPEAT_EN when the design is built with it.
module tb_multi_debounce;
  localparam int N_CH = 2, TICK_DIV = 4, STABLE_TICKS = 3, HOLD_TICKS = 8, REPEAT_TICKS = 2;

  logic            clk100M = 1'b0;
  logic            reset   = 1'b1;
  logic [N_CH-1:0] buttons = '0;
  logic [N_CH-1:0] level, press, release_pulse, hold;

  int checks   = 0;
  int failures = 0;

  always #5 clk100M = ~clk100M;

  multi_debounce #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk100M(clk100M), .reset(reset), .buttons(buttons), .level(level),
    .press(press), .release_pulse(release_pulse), .hold(hold)
  );

  // Reference model: edges since reset, a two-deep input delay, and per-channel
  // counts of consecutive disagreeing samples, ticks spent high, and ticks since hold.
  int              n_edge;
  logic [N_CH-1:0] d1, d2;
  logic [N_CH-1:0] m_level, m_press, m_release, m_hold;
  int              run  [N_CH];
  int              high [N_CH];
  int              rep  [N_CH];

  task automatic model_edge(input logic [N_CH-1:0] b, input logic r);
    logic [N_CH-1:0] s;
    logic            old;
    bit              tk;
    m_press = '0; m_release = '0; m_hold = '0;
    if (r) begin
      n_edge = 0; d1 = '0; d2 = '0; m_level = '0;
      for (int c = 0; c < N_CH; c++) begin run[c] = 0; high[c] = 0; rep[c] = 0; end
      return;
    end
    tk = ((n_edge % TICK_DIV) == TICK_DIV - 1);
    s = d2; d2 = d1; d1 = b;
    n_edge++;
    if (!tk) return;
    for (int c = 0; c < N_CH; c++) begin
      old = m_level[c];
      if (s[c] != old) run[c]++; else run[c] = 0;
      if (run[c] == STABLE_TICKS) begin
        run[c] = 0;
        m_level[c] = ~old;
        if (old) begin m_release[c] = 1'b1; high[c] = 0; rep[c] = 0; end
        else m_press[c] = 1'b1;
      end else if (old) begin
        if (high[c] < HOLD_TICKS) begin
          high[c]++;
          if (high[c] == HOLD_TICKS) m_hold[c] = 1'b1;
        end
`ifdef DEBOUNCE_REPEAT_EN
        else begin
          rep[c]++;
          if (rep[c] == REPEAT_TICKS) begin rep[c] = 0; m_press[c] = 1'b1; end
        end
`endif
      end
    end
  endtask

  task automatic step(input logic [N_CH-1:0] b, input logic r);
    buttons = b;
    reset   = r;
    @(posedge clk100M);
    model_edge(b, r);
    @(negedge clk100M);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step('0, 1'b1);
      checks++;
      if ({level, press, release_pulse, hold} !== '0) begin
        failures++;
        $display("FAIL reset_outputs got=%b want=0", {level, press, release_pulse, hold});
      end
    end
  endtask

  task automatic test_clean_press();
    int rise = -1, npress = 0;
    bit bad1 = 0;
    int idle = $urandom_range(0, 3);
    for (int i = 0; i < idle; i++) step('0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(2'b01, 1'b0);
      checks++;
      if ({level, press, release_pulse, hold} !== {m_level, m_press, m_release, m_hold}) begin
        failures++;
        $display("FAIL clean_model got=%b want=%b", {level, press, release_pulse, hold}, {m_level, m_press, m_release, m_hold});
      end
      if (level[0] && rise < 0) rise = i;
      if (press[0]) npress++;
      if (level[1] | press[1] | release_pulse[1] | hold[1]) bad1 = 1;
    end
    checks++;
    if (rise < 10 || rise > 14) begin failures++; $display("FAIL clean_latency got=%0d want=10..14", rise); end
    checks++;
    if (npress != 1) begin failures++; $display("FAIL clean_press_count got=%0d want=1", npress); end
    checks++;
    if (bad1) begin failures++; $display("FAIL clean_ch1_quiet got=1 want=0"); end
    for (int i = 0; i < 20; i++) begin
      step('0, 1'b0);
      checks++;
      if ({level, press, release_pulse, hold} !== {m_level, m_press, m_release, m_hold}) begin
        failures++;
        $display("FAIL clean_release_model got=%b want=%b", {level, press, release_pulse, hold}, {m_level, m_press, m_release, m_hold});
      end
    end
  endtask

  task automatic test_bounce();
    int pulses_bounce = 0, npress = 0;
    logic [N_CH-1:0] b;
    for (int i = 0; i < 50; i++) begin
      b = (i >= 30) ? 2'b01 : {1'b0, ((i / 3) % 2) == 0};
      step(b, 1'b0);
      checks++;
      if ({level, press, release_pulse, hold} !== {m_level, m_press, m_release, m_hold}) begin
        failures++;
        $display("FAIL bounce_model got=%b want=%b", {level, press, release_pulse, hold}, {m_level, m_press, m_release, m_hold});
      end
      if (i < 30 && (press[0] || release_pulse[0] || level[0])) pulses_bounce++;
      if (press[0]) npress++;
    end
    checks++;
    if (pulses_bounce != 0) begin failures++; $display("FAIL bounce_quiet got=%0d want=0", pulses_bounce); end
    checks++;
    if (npress != 1) begin failures++; $display("FAIL bounce_press_count got=%0d want=1", npress); end
    for (int i = 0; i < 20; i++) step('0, 1'b0);
    checks++;
    if (level !== '0) begin failures++; $display("FAIL bounce_settle got=%b want=00", level); end
  endtask

  task automatic test_hold();
    int rise = -1, hold_at = -1, nhold = 0, npress = 0, rep_at = -1;
    for (int i = 0; i < 60; i++) begin
      step(2'b10, 1'b0);
      checks++;
      if ({level, press, release_pulse, hold} !== {m_level, m_press, m_release, m_hold}) begin
        failures++;
        $display("FAIL hold_model got=%b want=%b", {level, press, release_pulse, hold}, {m_level, m_press, m_release, m_hold});
      end
      if (level[1] && rise < 0) rise = i;
      if (hold[1]) begin nhold++; hold_at = i; end
      if (press[1]) npress++;
      if (press[1] && hold_at >= 0 && rep_at < 0) rep_at = i;
    end
    checks++;
    if (nhold != 1) begin failures++; $display("FAIL hold_count got=%0d want=1", nhold); end
    checks++;
    if (hold_at - rise != 32) begin failures++; $display("FAIL hold_delay got=%0d want=32", hold_at - rise); end
`ifdef DEBOUNCE_REPEAT_EN
    checks++;
    if (rep_at - hold_at != 8) begin failures++; $display("FAIL repeat_delay got=%0d want=8", rep_at - hold_at); end
`else
    checks++;
    if (npress != 1) begin failures++; $display("FAIL hold_press_count got=%0d want=1", npress); end
`endif
    for (int i = 0; i < 20; i++) step('0, 1'b0);
  endtask

  task automatic test_simultaneous();
    int np = 0, nr = 0;
    bit split = 0;
    for (int i = 0; i < 40; i++) begin
      step((i < 20) ? 2'b11 : 2'b00, 1'b0);
      checks++;
      if ({level, press, release_pulse, hold} !== {m_level, m_press, m_release, m_hold}) begin
        failures++;
        $display("FAIL simul_model got=%b want=%b", {level, press, release_pulse, hold}, {m_level, m_press, m_release, m_hold});
      end
      if (press != 0) begin np++; if (press != 2'b11) split = 1; end
      if (release_pulse != 0) begin nr++; if (release_pulse != 2'b11) split = 1; end
    end
    checks++;
    if (split || np != 1 || nr != 1) begin
      failures++;
      $display("FAIL simul_coincide got=split%0d/p%0d/r%0d want=split0/p1/r1", split, np, nr);
    end
  endtask

  task automatic test_reset_mid();
    int rise = -1, refire = -1, nrel = 0;
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 1'b0);
      if (level[0] && rise < 0) rise = i;
    end
    checks++;
    if (rise < 0) begin failures++; $display("FAIL rstmid_rise got=timeout want=level1"); end
    step(2'b01, 1'b1);
    checks++;
    if ({level, press, release_pulse, hold} !== '0) begin
      failures++;
      $display("FAIL rstmid_clear got=%b want=0", {level, press, release_pulse, hold});
    end
    for (int i = 1; i <= 20; i++) begin
      step(2'b01, 1'b0);
      checks++;
      if ({level, press, release_pulse, hold} !== {m_level, m_press, m_release, m_hold}) begin
        failures++;
        $display("FAIL rstmid_model got=%b want=%b", {level, press, release_pulse, hold}, {m_level, m_press, m_release, m_hold});
      end
      if (press[0] && refire < 0) refire = i;
      if (release_pulse[0]) nrel++;
    end
    checks++;
    if (refire < 10 || refire > 14) begin failures++; $display("FAIL rstmid_refire got=%0d want=10..14", refire); end
    checks++;
    if (nrel != 0) begin failures++; $display("FAIL rstmid_no_release got=%0d want=0", nrel); end
    for (int i = 0; i < 20; i++) step('0, 1'b0);
  endtask

  task automatic test_release_at_hold();
    int i = 0, rel_at = -1, nrel = 0, nhold = 0;
    while (!level[0] && i < 20) begin step(2'b01, 1'b0); i++; end
    checks++;
    if (!level[0]) begin failures++; $display("FAIL relhold_rise got=timeout want=level1"); end
    for (int j = 1; j <= 39; j++) begin
      step((j <= 19) ? 2'b01 : 2'b00, 1'b0);
      checks++;
      if ({level, press, release_pulse, hold} !== {m_level, m_press, m_release, m_hold}) begin
        failures++;
        $display("FAIL relhold_model got=%b want=%b", {level, press, release_pulse, hold}, {m_level, m_press, m_release, m_hold});
      end
      if (release_pulse[0]) begin nrel++; rel_at = j; end
      if (hold[0]) nhold++;
    end
    checks++;
    if (nrel != 1 || rel_at != 32) begin failures++; $display("FAIL relhold_release got=%0d@%0d want=1@32", nrel, rel_at); end
    checks++;
    if (nhold != 0) begin failures++; $display("FAIL relhold_no_hold got=%0d want=0", nhold); end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] b = '0;
    int left [N_CH];
    logic r;
    for (int c = 0; c < N_CH; c++) left[c] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (left[c] == 0) begin
          b[c] = ~b[c];
          left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 14);
        end
        left[c]--;
      end
      r = ($urandom_range(0, 299) == 0);
      step(b, r);
      checks++;
      if ({level, press, release_pulse, hold} !== {m_level, m_press, m_release, m_hold}) begin
        failures++;
        $display("FAIL random_model i=%0d got=%b want=%b", i, {level, press, release_pulse, hold}, {m_level, m_press, m_release, m_hold});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold();
    test_simultaneous();
    test_reset_mid();
    test_release_at_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter N_CH, default 5: number of independent button channels, 1..16.
REQ-002 Parameter TICK_DIV, default 100_000: clk100M cycles per sample tick (1 ms at 100 MHz), >= 2.
REQ-003 Parameter STABLE_TICKS, default 20: consecutive disagreeing ticks required to accept a new level, 2..255.
REQ-004 Parameter HOLD_TICKS, default 500: ticks of continuous press before the hold pulse fires, > STABLE_TICKS, < 2^16.
REQ-005 Parameter REPEAT_TICKS, default 100: auto-repeat interval in ticks, 1..65535; used only with DEBOUNCE_REPEAT_EN.
REQ-006 clk100M  input  1  system clock, 100 MHz, all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 buttons  input  N_CH  raw asynchronous pushbutton levels, 1 = pressed.
REQ-009 level  output  N_CH  debounced level per channel.
REQ-010 press  output  N_CH  one-cycle pulse per accepted 0->1 transition (and per auto-repeat when enabled).
REQ-011 release  output  N_CH  one-cycle pulse per accepted 1->0 transition.
REQ-012 hold  output  N_CH  one-cycle pulse when a press has lasted HOLD_TICKS ticks.

Function
REQ-013 Each buttons bit SHALL pass through a two-flop synchroniser before any other use; raw inputs SHALL feed no other logic.
REQ-014 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-015 Per channel, on a tick: if the synchronised input differs from level, the stable counter SHALL increment; otherwise it SHALL clear to 0. Between ticks it SHALL hold.
REQ-016 When the stable counter would reach STABLE_TICKS on a tick, level SHALL toggle on that edge and the counter SHALL clear; a single agreeing tick in between restarts the count.
REQ-017 press (release) SHALL assert in the same cycle that level first reads 1 (0), for exactly one cycle.
REQ-018 Input-to-level latency SHALL be 2 sync cycles plus between STABLE_TICKS-1 and STABLE_TICKS full tick periods; no faster path exists.
REQ-019 Per channel, a hold counter SHALL count ticks while level = 1, clear to 0 in the cycle level falls, and saturate at HOLD_TICKS.
REQ-020 hold SHALL pulse for one cycle on the tick the hold counter reaches HOLD_TICKS; it fires at most once per press.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 A release accepted on the same tick as the hold threshold SHALL emit release and SHALL NOT emit hold.
REQ-023 Counter widths SHALL be derived from the parameters by $clog2; no counter SHALL wrap except the prescaler.

Reset
REQ-024 While reset is high: prescaler, synchronisers, stable, hold and repeat counters SHALL be 0, and level, press, release and hold SHALL be 0.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abandon the operation with no pulse emitted; after release a held button SHALL be re-accepted as a fresh press.

Configuration
REQ-026 Macro DEBOUNCE_REPEAT_EN defined: after hold fires, a per-channel repeat counter SHALL emit an extra press pulse every REPEAT_TICKS ticks until level falls; the counter clears on level fall and on reset.
REQ-027 Macro DEBOUNCE_REPEAT_EN undefined: no repeat logic SHALL be synthesised; press pulses only on accepted 0->1 transitions.

Verification (N_CH=2, TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=8, REPEAT_TICKS=2)
REQ-028 Clean press ch0 held 40 cycles -> level[0] rises 10..14 cycles after the input edge, press[0] one cycle wide, ch1 outputs stay 0.
REQ-029 Bounce ch0 toggling every 3 cycles for 30 cycles, then stable 1 -> no pulses during bounce; exactly one press[0] after the stable window.
REQ-030 Hold ch1 for 60 cycles -> hold[1] exactly once, 32 cycles (8 ticks) after level[1] rises; with DEBOUNCE_REPEAT_EN, further press[1] every 8 cycles afterwards.
REQ-031 Press both channels on the same cycle -> press[0] and press[1] in the same cycle; release both -> release pulses coincide.
REQ-032 Assert reset for 1 cycle while ch0 is held, after level[0] = 1 -> all outputs 0 next cycle, no release[0]; press[0] re-fires 10..14 cycles after reset drops.
REQ-033 Release ch0 timed so acceptance lands on tick 8 of the hold count -> release[0] pulses, hold[0] never asserts.
